// File: rtl/eth_cmd_rx.sv
// Receive-side command parser: extracts sensor command words from frames addressed to this board
// and releases them to the SPI configuration block only after the frame's FCS has been verified.
module eth_cmd_rx #(
    parameter logic [47:0] MY_MAC    = 48'h00_23_54_3C_47_1B,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int unsigned FIFO_AW   = 3,
    parameter int unsigned CMD_MAX   = 8
) (
    input  logic        pll_clk_rx,
    input  logic        rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_dv,
    output logic [32:0] o_cmd_data,
    output logic        o_cmd_vld,
    input  logic        i_cmd_rdy,
    output logic        o_frame_ok,
    output logic        o_frame_err
);
    localparam int unsigned      Depth      = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DepthP     = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] PtrOne     = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [7:0]       CmdMax8    = 8'(CMD_MAX);
    localparam logic [31:0]      CrcResidue = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        StIdle, StPre, StHdr, StCnt, StCmd, StTail, StDrop, StBad
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      crc_q, crc_d, crc_upd;
    logic [3:0]       hdr_idx_q, hdr_idx_d;
    logic             uc_ok_q, uc_ok_d, bc_ok_q, bc_ok_d;
    logic [6:0]       len_q, len_d;
    logic [7:0]       n_q, n_d, done_q, done_d;
    logic [1:0]       cb_q, cb_d;
    logic             addr_q, addr_d;
    logic [7:0]       hi_q, hi_d;
    logic [FIFO_AW:0] rd_q, rd_d, wr_spec_q, wr_spec_d, wr_cmt_q, wr_cmt_d;
    logic             ok_q, ok_d, err_q, err_d;
    logic             we;
    logic [7:0]       mac_byte;
    logic [16:0]      mem_q [Depth];

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign crc_upd = crc_byte(crc_q, i_rx_data);

    always_comb begin
        case (hdr_idx_q)
            4'd0:    mac_byte = MY_MAC[47:40];
            4'd1:    mac_byte = MY_MAC[39:32];
            4'd2:    mac_byte = MY_MAC[31:24];
            4'd3:    mac_byte = MY_MAC[23:16];
            4'd4:    mac_byte = MY_MAC[15:8];
            4'd5:    mac_byte = MY_MAC[7:0];
            default: mac_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        hdr_idx_d = hdr_idx_q;
        uc_ok_d   = uc_ok_q;
        bc_ok_d   = bc_ok_q;
        len_d     = len_q;
        n_d       = n_q;
        done_d    = done_q;
        cb_d      = cb_q;
        addr_d    = addr_q;
        hi_d      = hi_q;
        rd_d      = rd_q;
        wr_spec_d = wr_spec_q;
        wr_cmt_d  = wr_cmt_q;
        ok_d      = 1'b0;
        err_d     = 1'b0;
        we        = 1'b0;

        if (o_cmd_vld && i_cmd_rdy) rd_d = rd_q + PtrOne;

        // CRC and length cover every byte after the SFD, FCS included.
        if (i_rx_dv && (state_q inside {StHdr, StCnt, StCmd, StTail})) begin
            crc_d = crc_upd;
            if (len_q != 7'h7F) len_d = len_q + 7'd1;
        end

        unique case (state_q)
            StIdle, StPre: begin
                if (!i_rx_dv) begin
                    state_d = StIdle;
                end else if (i_rx_data == 8'hD5) begin
                    state_d   = StHdr;
                    crc_d     = 32'hFFFF_FFFF;
                    len_d     = 7'd0;
                    hdr_idx_d = 4'd0;
                end else if (i_rx_data == 8'h55) begin
                    state_d = StPre;
                end else begin
                    state_d = StDrop;
                end
            end
            StHdr: begin
                if (!i_rx_dv) begin
                    state_d = StIdle;
                end else begin
                    hdr_idx_d = hdr_idx_q + 4'd1;
                    if (hdr_idx_q < 4'd6) begin
                        uc_ok_d = (uc_ok_q || hdr_idx_q == 4'd0) && (i_rx_data == mac_byte);
                        bc_ok_d = (bc_ok_q || hdr_idx_q == 4'd0) && (i_rx_data == 8'hFF);
                        if (hdr_idx_q == 4'd5 && !uc_ok_d && !bc_ok_d) state_d = StDrop;
                    end else if (hdr_idx_q == 4'd12) begin
                        if (i_rx_data != ETHERTYPE[15:8]) state_d = StDrop;
                    end else if (hdr_idx_q == 4'd13) begin
                        state_d = (i_rx_data == ETHERTYPE[7:0]) ? StCnt : StDrop;
                    end
                end
            end
            StCnt: begin
                if (!i_rx_dv) begin
                    state_d   = StIdle;
                    err_d     = 1'b1;
                    wr_spec_d = wr_cmt_q;
                end else begin
                    n_d     = i_rx_data;
                    done_d  = 8'd0;
                    cb_d    = 2'd0;
                    state_d = (i_rx_data == 8'd0 || i_rx_data > CmdMax8) ? StBad : StCmd;
                end
            end
            StCmd: begin
                if (!i_rx_dv) begin
                    state_d   = StIdle;
                    err_d     = 1'b1;
                    wr_spec_d = wr_cmt_q;
                end else begin
                    cb_d = cb_q + 2'd1;
                    unique case (cb_q)
                        2'd0:    addr_d = i_rx_data[0];
                        2'd1:    hi_d   = i_rx_data;
                        default: begin
                            cb_d = 2'd0;
                            // Never overwrite an entry the consumer has not yet taken.
                            if (wr_spec_q - rd_q == DepthP) begin
                                state_d = StBad;
                            end else begin
                                we        = 1'b1;
                                wr_spec_d = wr_spec_q + PtrOne;
                                done_d    = done_q + 8'd1;
                                if (done_d == n_q) state_d = StTail;
                            end
                        end
                    endcase
                end
            end
            StTail: begin
                if (!i_rx_dv) begin
                    state_d = StIdle;
                    if (crc_q == CrcResidue && len_q >= 7'd64) begin
                        wr_cmt_d = wr_spec_q;
                        ok_d     = 1'b1;
                    end else begin
                        wr_spec_d = wr_cmt_q;
                        err_d     = 1'b1;
                    end
                end
            end
            StDrop: begin
                if (!i_rx_dv) state_d = StIdle;
            end
            StBad: begin
                if (!i_rx_dv) begin
                    state_d   = StIdle;
                    err_d     = 1'b1;
                    wr_spec_d = wr_cmt_q;
                end
            end
        endcase
    end

    always_ff @(posedge pll_clk_rx or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            crc_q     <= 32'hFFFF_FFFF;
            hdr_idx_q <= 4'd0;
            uc_ok_q   <= 1'b0;
            bc_ok_q   <= 1'b0;
            len_q     <= 7'd0;
            n_q       <= 8'd0;
            done_q    <= 8'd0;
            cb_q      <= 2'd0;
            addr_q    <= 1'b0;
            hi_q      <= 8'd0;
            rd_q      <= '0;
            wr_spec_q <= '0;
            wr_cmt_q  <= '0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            hdr_idx_q <= hdr_idx_d;
            uc_ok_q   <= uc_ok_d;
            bc_ok_q   <= bc_ok_d;
            len_q     <= len_d;
            n_q       <= n_d;
            done_q    <= done_d;
            cb_q      <= cb_d;
            addr_q    <= addr_d;
            hi_q      <= hi_d;
            rd_q      <= rd_d;
            wr_spec_q <= wr_spec_d;
            wr_cmt_q  <= wr_cmt_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge pll_clk_rx) begin
        if (we) mem_q[wr_spec_q[FIFO_AW-1:0]] <= {addr_q, hi_q, i_rx_data};
    end

    assign o_cmd_vld   = (rd_q != wr_cmt_q);
    assign o_cmd_data  = o_cmd_vld ? {16'h0, mem_q[rd_q[FIFO_AW-1:0]]} : 33'h0;
    assign o_frame_ok  = ok_q;
    assign o_frame_err = err_q;

endmodule

// File: tb/tb_eth_cmd_rx.sv
// Randomized and directed bench for eth_cmd_rx; expected words and frame outcomes come from a
// frame-level model of the acceptance rules.
module tb_eth_cmd_rx;
    localparam logic [47:0] MyMac   = 48'h00_23_54_3C_47_1B;
    localparam logic [47:0] Bcast   = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] Foreign = 48'h00_11_22_33_44_55;
    localparam logic [15:0] EType   = 16'h88B5;

    typedef logic [7:0]  bq_t[$];
    typedef logic [16:0] wq_t[$];

    logic        pll_clk_rx = 1'b0;
    logic        rst_n;
    logic [7:0]  i_rx_data;
    logic        i_rx_dv;
    logic [32:0] o_cmd_data;
    logic        o_cmd_vld;
    logic        i_cmd_rdy;
    logic        o_frame_ok;
    logic        o_frame_err;

    int          checks   = 0;
    int          failures = 0;
    int          ok_cnt   = 0;
    int          err_cnt  = 0;
    bit          rdy_rand = 1'b0;
    logic [32:0] exp_q[$];

    always #4 pll_clk_rx = ~pll_clk_rx;

    eth_cmd_rx dut (
        .pll_clk_rx (pll_clk_rx),
        .rst_n      (rst_n),
        .i_rx_data  (i_rx_data),
        .i_rx_dv    (i_rx_dv),
        .o_cmd_data (o_cmd_data),
        .o_cmd_vld  (o_cmd_vld),
        .i_cmd_rdy  (i_cmd_rdy),
        .o_frame_ok (o_frame_ok),
        .o_frame_err(o_frame_err)
    );

    // Output monitor: pulse counting and scoreboard of delivered command words.
    always @(negedge pll_clk_rx) begin
        if (rst_n) begin
            if (o_frame_ok) ok_cnt++;
            if (o_frame_err) err_cnt++;
            if (o_cmd_vld) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL cmd_unexpected got=%h required=no_valid", o_cmd_data);
                end else begin
                    if (o_cmd_data !== exp_q[0]) begin
                        failures++;
                        $display("FAIL cmd_data got=%h required=%h", o_cmd_data, exp_q[0]);
                    end
                    if (i_cmd_rdy) exp_q.delete(0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge pll_clk_rx);
        #1;
        if (rdy_rand) i_cmd_rdy = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [31:0] crc32(input bq_t f);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (f[i]) begin
            c ^= {24'h0, f[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // Bytes after the SFD: header, count, commands, padding, FCS.
    task automatic build(input logic [47:0] da, input logic [15:0] et, input int n,
                         input wq_t w, input int pad, output bq_t f);
        logic [31:0] fcs;
        f = {};
        for (int i = 0; i < 6; i++) f.push_back(da[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) f.push_back(8'($urandom));
        f.push_back(et[15:8]);
        f.push_back(et[7:0]);
        f.push_back(8'(n));
        foreach (w[k]) begin
            f.push_back({7'($urandom), w[k][16]});
            f.push_back(w[k][15:8]);
            f.push_back(w[k][7:0]);
        end
        for (int i = 0; i < pad; i++) f.push_back(8'($urandom));
        fcs = ~crc32(f);
        for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
    endtask

    // 0: ignored, 1: committed, 2: rejected with an error pulse.
    function automatic int predict(input logic [47:0] da, input logic [15:0] et, input int n,
                                   input int len, input bit corrupt, input int occ);
        if (!(da == MyMac || da == Bcast) || et != EType) return 0;
        if (n < 1 || n > 8) return 2;
        if (occ + n > 8) return 2;
        if (len < 64 || corrupt) return 2;
        return 1;
    endfunction

    function automatic int pad64(input int nw);
        return (45 - 3 * nw > 0) ? 45 - 3 * nw : 0;
    endfunction

    task automatic send(input bq_t f);
        i_rx_dv = 1'b1;
        for (int i = 0; i < 7; i++) begin
            i_rx_data = 8'h55;
            tick();
        end
        i_rx_data = 8'hD5;
        tick();
        foreach (f[i]) begin
            i_rx_data = f[i];
            tick();
        end
        i_rx_dv   = 1'b0;
        i_rx_data = 8'h00;
    endtask

    task automatic run_frame(input logic [47:0] da, input logic [15:0] et, input int n,
                             input wq_t w, input int pad, input bit corrupt, input int gap,
                             output int res);
        bq_t f;
        build(da, et, n, w, pad, f);
        if (corrupt) f[f.size()-1] ^= 8'hFF;
        res = predict(da, et, n, f.size(), corrupt, exp_q.size());
        send(f);
        if (res == 1) foreach (w[k]) exp_q.push_back({16'h0, w[k]});
        repeat (gap) tick();
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_rx_dv = 1'b0; i_rx_data = 8'h00; i_cmd_rdy = 1'b1;
        #2;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks += 4;
        if (o_cmd_vld !== 1'b0) begin
            failures++; $display("FAIL reset_vld got=%b required=0", o_cmd_vld);
        end
        if (o_cmd_data !== 33'h0) begin
            failures++; $display("FAIL reset_data got=%h required=0", o_cmd_data);
        end
        if (o_frame_ok !== 1'b0) begin
            failures++; $display("FAIL reset_ok got=%b required=0", o_frame_ok);
        end
        if (o_frame_err !== 1'b0) begin
            failures++; $display("FAIL reset_err got=%b required=0", o_frame_err);
        end
    endtask

    task automatic test_good_frame();
        int ok0, err0, res;
        wq_t w;
        w = '{17'h11234, 17'h0ABCD};
        ok0 = ok_cnt; err0 = err_cnt;
        run_frame(MyMac, EType, 2, w, pad64(2), 1'b0, 6, res);
        checks += 3;
        if (ok_cnt - ok0 !== 1) begin
            failures++; $display("FAIL good_ok got=%0d required=1", ok_cnt - ok0);
        end
        if (err_cnt - err0 !== 0) begin
            failures++; $display("FAIL good_err got=%0d required=0", err_cnt - err0);
        end
        if (exp_q.size() !== 0) begin
            failures++; $display("FAIL good_drain got=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_bad_fcs();
        int ok0, err0, res;
        wq_t w;
        w = '{17'h11234, 17'h0ABCD};
        ok0 = ok_cnt; err0 = err_cnt;
        run_frame(MyMac, EType, 2, w, pad64(2), 1'b1, 6, res);
        checks += 3;
        if (err_cnt - err0 !== 1) begin
            failures++; $display("FAIL fcs_err got=%0d required=1", err_cnt - err0);
        end
        if (ok_cnt - ok0 !== 0) begin
            failures++; $display("FAIL fcs_ok got=%0d required=0", ok_cnt - ok0);
        end
        if (o_cmd_vld !== 1'b0) begin
            failures++; $display("FAIL fcs_vld got=%b required=0", o_cmd_vld);
        end
    endtask

    task automatic test_filter();
        int ok0, err0, res;
        wq_t w;
        w = '{17'h1_5A5A};
        ok0 = ok_cnt; err0 = err_cnt;
        run_frame(Foreign, EType, 1, w, pad64(1), 1'b0, 4, res);
        run_frame(MyMac, 16'h88B4, 1, w, pad64(1), 1'b0, 4, res);
        checks += 2;
        if (ok_cnt - ok0 !== 0 || err_cnt - err0 !== 0) begin
            failures++;
            $display("FAIL filter_pulses got=ok%0d/err%0d required=ok0/err0",
                     ok_cnt - ok0, err_cnt - err0);
        end
        if (o_cmd_vld !== 1'b0) begin
            failures++; $display("FAIL filter_vld got=%b required=0", o_cmd_vld);
        end
        w = '{17'h0_C3C3};
        ok0 = ok_cnt;
        run_frame(Bcast, EType, 1, w, pad64(1), 1'b0, 6, res);
        checks += 2;
        if (ok_cnt - ok0 !== 1) begin
            failures++; $display("FAIL bcast_ok got=%0d required=1", ok_cnt - ok0);
        end
        if (exp_q.size() !== 0) begin
            failures++; $display("FAIL bcast_drain got=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_len_boundary();
        int ok0, err0, res;
        wq_t w;
        w = '{17'h0_1111, 17'h1_2222};
        ok0 = ok_cnt; err0 = err_cnt;
        run_frame(MyMac, EType, 2, w, pad64(2) - 1, 1'b0, 4, res);   // 63 bytes
        checks += 2;
        if (err_cnt - err0 !== 1 || ok_cnt - ok0 !== 0) begin
            failures++;
            $display("FAIL len63 got=ok%0d/err%0d required=ok0/err1", ok_cnt - ok0, err_cnt - err0);
        end
        if (o_cmd_vld !== 1'b0) begin
            failures++; $display("FAIL len63_vld got=%b required=0", o_cmd_vld);
        end
        ok0 = ok_cnt; err0 = err_cnt;
        run_frame(MyMac, EType, 2, w, pad64(2), 1'b0, 6, res);       // 64 bytes
        checks += 1;
        if (ok_cnt - ok0 !== 1 || err_cnt - err0 !== 0) begin
            failures++;
            $display("FAIL len64 got=ok%0d/err%0d required=ok1/err0", ok_cnt - ok0, err_cnt - err0);
        end
    endtask

    task automatic test_bad_count();
        int ok0, err0, res;
        wq_t w;
        w = {};
        for (int n = 0; n <= 9; n += 9) begin
            ok0 = ok_cnt; err0 = err_cnt;
            run_frame(MyMac, EType, n, w, 60, 1'b0, 4, res);
            checks++;
            if (err_cnt - err0 !== 1 || ok_cnt - ok0 !== 0) begin
                failures++;
                $display("FAIL count_n%0d got=ok%0d/err%0d required=ok0/err1",
                         n, ok_cnt - ok0, err_cnt - err0);
            end
        end
    endtask

    task automatic test_overflow();
        int ok0, err0, res;
        wq_t w;
        i_cmd_rdy = 1'b0;
        ok0 = ok_cnt; err0 = err_cnt;
        for (int f = 0; f < 3; f++) begin
            w = {};
            for (int k = 0; k < 3; k++) w.push_back(17'($urandom));
            run_frame(MyMac, EType, 3, w, pad64(3), 1'b0, 4, res);
        end
        checks += 3;
        if (ok_cnt - ok0 !== 2) begin
            failures++; $display("FAIL ovf_ok got=%0d required=2", ok_cnt - ok0);
        end
        if (err_cnt - err0 !== 1) begin
            failures++; $display("FAIL ovf_err got=%0d required=1", err_cnt - err0);
        end
        if (o_cmd_vld !== 1'b1) begin
            failures++; $display("FAIL ovf_held got=%b required=1", o_cmd_vld);
        end
        i_cmd_rdy = 1'b1;
        wait_drain(40);
        tick();
        checks += 2;
        if (exp_q.size() !== 0) begin
            failures++; $display("FAIL ovf_drain got=%0d required=0", exp_q.size());
        end
        if (o_cmd_vld !== 1'b0) begin
            failures++; $display("FAIL ovf_empty got=%b required=0", o_cmd_vld);
        end
    endtask

    task automatic test_truncate();
        int ok0, err0, res;
        wq_t w;
        bq_t f;
        w = '{17'h1_0101, 17'h0_0202};
        build(MyMac, EType, 2, w, pad64(2), f);
        f = f[0:19];                        // stops after b1 of the second command
        ok0 = ok_cnt; err0 = err_cnt;
        send(f);
        repeat (4) tick();
        checks++;
        if (err_cnt - err0 !== 1 || ok_cnt - ok0 !== 0) begin
            failures++;
            $display("FAIL trunc got=ok%0d/err%0d required=ok0/err1", ok_cnt - ok0, err_cnt - err0);
        end
        w = '{17'h1_7E81};
        ok0 = ok_cnt;
        run_frame(MyMac, EType, 1, w, pad64(1), 1'b0, 6, res);
        checks += 2;
        if (ok_cnt - ok0 !== 1) begin
            failures++; $display("FAIL trunc_next_ok got=%0d required=1", ok_cnt - ok0);
        end
        if (exp_q.size() !== 0) begin
            failures++; $display("FAIL trunc_next_drain got=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int ok0, err0, res;
        wq_t w;
        ok0 = ok_cnt; err0 = err_cnt;
        for (int f = 0; f < 3; f++) begin
            w = {};
            for (int k = 0; k < 2; k++) w.push_back(17'($urandom));
            run_frame(MyMac, EType, 2, w, pad64(2), 1'b0, 1, res);
        end
        repeat (6) tick();
        checks += 2;
        if (ok_cnt - ok0 !== 3 || err_cnt - err0 !== 0) begin
            failures++;
            $display("FAIL b2b got=ok%0d/err%0d required=ok3/err0", ok_cnt - ok0, err_cnt - err0);
        end
        if (exp_q.size() !== 0) begin
            failures++; $display("FAIL b2b_drain got=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_random();
        int ok0, err0, res, n, nw, pad, gap;
        logic [47:0] da;
        logic [15:0] et;
        bit corrupt;
        wq_t w;
        rdy_rand = 1'b1;
        for (int it = 0; it < 40; it++) begin
            wait_drain(200);
            checks++;
            if (exp_q.size() !== 0) begin
                failures++; $display("FAIL rand_drain it=%0d got=%0d required=0", it, exp_q.size());
                exp_q.delete();
            end
            case ($urandom_range(0, 5))
                0:       da = Foreign;
                1:       da = Bcast;
                default: da = MyMac;
            endcase
            et      = ($urandom_range(0, 7) == 0) ? 16'h88B4 : EType;
            n       = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9))
                                                  : int'($urandom_range(1, 8));
            nw      = (n >= 1 && n <= 8) ? n : 0;
            pad     = pad64(nw) + int'($urandom_range(0, 3)) - 1;
            pad     = (pad < 0) ? 0 : pad;
            corrupt = ($urandom_range(0, 5) == 0);
            gap     = $urandom_range(2, 5);
            w = {};
            for (int k = 0; k < nw; k++) w.push_back(17'($urandom));
            ok0 = ok_cnt; err0 = err_cnt;
            run_frame(da, et, n, w, pad, corrupt, gap, res);
            checks++;
            if (ok_cnt - ok0 !== int'(res == 1) || err_cnt - err0 !== int'(res == 2)) begin
                failures++;
                $display("FAIL rand_pulses it=%0d got=ok%0d/err%0d required=ok%0d/err%0d",
                         it, ok_cnt - ok0, err_cnt - err0, int'(res == 1), int'(res == 2));
            end
        end
        rdy_rand  = 1'b0;
        i_cmd_rdy = 1'b1;
        wait_drain(50);
    endtask

    task automatic test_reset_mid();
        int ok0, res;
        wq_t w;
        bq_t f;
        i_cmd_rdy = 1'b0;
        w = '{17'h1_AAAA, 17'h0_5555};
        run_frame(MyMac, EType, 2, w, pad64(2), 1'b0, 4, res);
        w = '{17'h0_1234, 17'h1_4321, 17'h0_0F0F};
        build(MyMac, EType, 3, w, pad64(3), f);
        f = f[0:18];                        // mid second command
        send(f);
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        tick();
        checks += 2;
        if (o_cmd_vld !== 1'b0 || o_cmd_data !== 33'h0) begin
            failures++;
            $display("FAIL rstmid_cmd got=%b/%h required=0/0", o_cmd_vld, o_cmd_data);
        end
        if (o_frame_ok !== 1'b0 || o_frame_err !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_pulse got=%b/%b required=0/0", o_frame_ok, o_frame_err);
        end
        rst_n = 1'b1;
        i_cmd_rdy = 1'b1;
        tick();
        checks++;
        if (o_cmd_vld !== 1'b0) begin
            failures++; $display("FAIL rstmid_after got=%b required=0", o_cmd_vld);
        end
        w = '{17'h1_BEEF};
        ok0 = ok_cnt;
        run_frame(MyMac, EType, 1, w, pad64(1), 1'b0, 6, res);
        checks += 2;
        if (ok_cnt - ok0 !== 1) begin
            failures++; $display("FAIL rstmid_next_ok got=%0d required=1", ok_cnt - ok0);
        end
        if (exp_q.size() !== 0) begin
            failures++; $display("FAIL rstmid_next_drain got=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_fcs();
        test_filter();
        test_len_boundary();
        test_bad_count();
        test_overflow();
        test_truncate();
        test_back_to_back();
        test_random();
        test_reset_mid();
        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
